snake_body: RTL and testbench
=============================

# snake_body

Snake movement and body-tracking stage of the snake game. On each move tick it advances the head one cell on the 32x24 grid and shifts the body. It detects wall and self collisions, compares the new head against the current food cell, and raises `get_food` for one cycle so the food generator relocates the food. It also answers per-cell occupancy queries for the display renderer.

## Interface
- `MAX_LEN`, 16: maximum segment count (head included); 2..31.
- `INIT_LEN`, 3: segment count after init; 2..MAX_LEN.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `game_state` input 2: 2'b00 idle, 2'b01 playing, 2'b10 paused, 2'b11 over.
- `step` input 1: one-cycle move tick from the game timer.
- `dir_req` input 2: requested direction; 2'b00 up (y-1), 2'b01 down (y+1), 2'b10 left (x-1), 2'b11 right (x+1).
- `food_x` input 5: food column, 0..31.
- `food_y` input 5: food row, 0..23.
- `query_x`, `query_y` input 5 each: renderer cell probe.
- `get_food` output 1: registered one-cycle pulse; the head moved onto the food.
- `head_x`, `head_y` output 5 each: registered head position.
- `length` output 5: registered segment count, INIT_LEN..MAX_LEN.
- `crash` output 1: registered, sticky collision flag.
- `query_hit` output 1: combinational; high when (query_x, query_y) is an active segment.

## Operation
- Storage: segment arrays `seg_x[0..MAX_LEN-1]` and `seg_y[0..MAX_LEN-1]`; index 0 is the head. Segments with index < `length` are active.
- Init configuration, applied on `rst` and on every cycle with `game_state`==2'b00:
  - Segment i at (16-i, 12) for i < INIT_LEN.
  - `length`=INIT_LEN, current direction = right.
  - `crash`=0, `get_food`=0.
  - Reset values: `head_x`=16, `head_y`=12, `length`=INIT_LEN, `crash`=0, `get_food`=0.
- Direction latch:
  - While `game_state`==2'b01, `dir_req` is sampled every cycle into a pending direction.
  - A request opposite to the last direction actually moved is dropped.
  - The pending direction becomes the current direction only when a step executes.
- Internal FSM, states INIT, RUN, DEAD:
  - INIT -> RUN when `game_state`==2'b01.
  - RUN -> DEAD on a detected collision.
  - Any state -> INIT on `rst` or `game_state`==2'b00.
  - Paused (2'b10) and over (2'b11) freeze all state in RUN or DEAD.
- Step, in RUN with `game_state`==2'b01 and `step`=1:
  - Compute the next head from the current direction.
  - Wall collision: x==0 moving left, x==31 moving right, y==0 moving up, or y==23 moving down.
  - Eat: the next head equals (`food_x`, `food_y`).
  - Self collision: the next head equals any segment with index <= `length`-2. The tail (index `length`-1) is also checked when eating with `length` < MAX_LEN, because the tail does not vacate in that case.
  - On any collision: `crash`<=1 and go to DEAD; segments, `length` and `get_food` are unchanged.
  - Otherwise: shift `seg[i]`<=`seg[i-1]` for i>=1 and load `seg[0]` with the next head.
  - If eating: `get_food`<=1, and `length`<=`length`+1 if `length` < MAX_LEN. At MAX_LEN the pulse still fires and the length saturates.
- `step` is ignored in INIT, DEAD, paused and over. `crash` clears only via `rst` or idle.
- `query_hit` ORs the equality compare over active segments; no registering.

## Timing
- A step sampled at edge N updates `head_x/y`, the segments, `length`, `crash` and `get_food`, all visible after edge N.
- `get_food` is high for exactly one cycle after the eating step, then 0. The food block samples it during that cycle.
- Back-to-back `step` on consecutive cycles is legal. Each step uses the segments and food position registered before it.
- Food updates caused by `get_food` are seen from the next step onward.
- `rst` has priority over every other input on the same edge.
- `game_state` changing on the same edge as `step`: the `game_state` value sampled on that edge decides; a step executes only if it is 2'b01.
- Crash and eat on the same step: crash wins, `get_food` stays 0.

## Test plan
- Reset, then `game_state`=01 and 3 steps with no `dir_req` change -> head (19,12), `length`=3, segments (19,12),(18,12),(17,12), no `get_food`.
- Food at (17,12), 1 step -> `get_food` pulses for 1 cycle, `length`=4, tail at (14,12).
- With current direction right, `dir_req`=left, then 1 step -> request dropped, head (17,12). Then `dir_req`=up, 1 step -> head (17,11).
- Drive the head to x=31 moving right, then step -> `crash`=1, head stays (31,y). Further steps change nothing. `game_state`=00 -> init configuration restored, `crash`=0.
- Grow to 5 segments, then turn down, left, up -> head re-enters its own body: `crash`=1 and `length` unchanged. Repeat at length 4 chasing the tail cell -> no crash, because the tail vacates.
- MAX_LEN=4: eat twice -> `length` saturates at 4 while `get_food` still pulses each time. `game_state`=10 with steps -> frozen. Probe (`query_x`, `query_y`) at the head -> `query_hit`=1; probe at a free cell -> `query_hit`=0.

Source files
------------

// File: rtl/snake_body.sv
// snake_body: snake head movement, body shifting, wall/self collision,
// food detection and per-cell occupancy lookup on a 32x24 grid.
module snake_body #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] game_state,
    input  logic       step,
    input  logic [1:0] dir_req,
    input  logic [4:0] food_x,
    input  logic [4:0] food_y,
    input  logic [4:0] query_x,
    input  logic [4:0] query_y,
    output logic       get_food,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [4:0] length,
    output logic       crash,
    output logic       query_hit
);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_PLAY = 2'b01;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [4:0] MAX_LEN_V  = 5'(MAX_LEN);
    localparam logic [4:0] INIT_LEN_V = 5'(INIT_LEN);

    logic [4:0] seg_x_q [MAX_LEN];
    logic [4:0] seg_y_q [MAX_LEN];
    logic [4:0] seg_x_d [MAX_LEN];
    logic [4:0] seg_y_d [MAX_LEN];
    logic [4:0] init_x  [MAX_LEN];
    logic [4:0] init_y  [MAX_LEN];

    logic [4:0] length_q, length_d;
    logic [1:0] dir_cur_q, dir_cur_d;     // direction of the last executed move
    logic [1:0] dir_pend_q, dir_pend_d;   // direction the next step will take
    logic       crash_q, crash_d;
    logic       get_food_q, get_food_d;
    logic [1:0] fsm_q, fsm_d;

    logic [4:0] next_x, next_y;
    logic       wall;
    logic       eat;
    logic       eat_grow;
    logic [4:0] chk_lim;
    logic       step_go;
    logic       collide;

    logic [MAX_LEN-1:0] body_hit;
    logic [MAX_LEN-1:0] occ_hit;

    // Starting layout: a horizontal line heading right from (16,12).
    // Slots beyond the starting length are inactive, so their contents are don't-care.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_init
            if (gi < INIT_LEN) begin : g_act
                localparam int X_INIT = 16 - gi;
                assign init_x[gi] = 5'(X_INIT);
            end else begin : g_idle
                assign init_x[gi] = 5'd0;
            end
            assign init_y[gi] = 5'd12;
        end
    endgenerate

    // Next head cell and wall test, using the direction the step will take
    always_comb begin
        next_x = seg_x_q[0];
        next_y = seg_y_q[0];
        wall   = 1'b0;
        case (dir_pend_q)
            DIR_UP: begin
                wall   = (seg_y_q[0] == 5'd0);
                next_y = seg_y_q[0] - 5'd1;
            end
            DIR_DOWN: begin
                wall   = (seg_y_q[0] == 5'd23);
                next_y = seg_y_q[0] + 5'd1;
            end
            DIR_LEFT: begin
                wall   = (seg_x_q[0] == 5'd0);
                next_x = seg_x_q[0] - 5'd1;
            end
            default: begin
                wall   = (seg_x_q[0] == 5'd31);
                next_x = seg_x_q[0] + 5'd1;
            end
        endcase
    end

    assign eat      = (next_x == food_x) && (next_y == food_y);
    assign eat_grow = eat && (length_q < MAX_LEN_V);
    // The tail normally vacates its cell on a move; when growing it stays put,
    // so the tail index joins the set of cells the new head may not enter.
    assign chk_lim  = eat_grow ? length_q : (length_q - 5'd1);

    // Per-segment compares: body collision against the next head, and
    // occupancy against the renderer probe.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
            assign body_hit[gi] = (seg_x_q[gi] == next_x) && (seg_y_q[gi] == next_y)
                                  && (5'(gi) < chk_lim);
            assign occ_hit[gi]  = (seg_x_q[gi] == query_x) && (seg_y_q[gi] == query_y)
                                  && (5'(gi) < length_q);
        end
    endgenerate

    assign query_hit = |occ_hit;
    assign step_go   = (fsm_q == ST_RUN) && (game_state == GS_PLAY) && step;
    assign collide   = wall || (|body_hit);

    // Next-state logic: init on idle, otherwise FSM, step execution and direction latch
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i];
            seg_y_d[i] = seg_y_q[i];
        end
        length_d   = length_q;
        dir_cur_d  = dir_cur_q;
        dir_pend_d = dir_pend_q;
        crash_d    = crash_q;
        get_food_d = 1'b0;
        fsm_d      = fsm_q;

        if (game_state == GS_IDLE) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = init_x[i];
                seg_y_d[i] = init_y[i];
            end
            length_d   = INIT_LEN_V;
            dir_cur_d  = DIR_RIGHT;
            dir_pend_d = DIR_RIGHT;
            crash_d    = 1'b0;
            fsm_d      = ST_INIT;
        end else begin
            case (fsm_q)
                ST_INIT: begin
                    if (game_state == GS_PLAY) begin
                        fsm_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (step_go) begin
                        if (collide) begin
                            crash_d = 1'b1;
                            fsm_d   = ST_DEAD;
                        end else begin
                            for (int i = 1; i < MAX_LEN; i++) begin
                                seg_x_d[i] = seg_x_q[i-1];
                                seg_y_d[i] = seg_y_q[i-1];
                            end
                            seg_x_d[0] = next_x;
                            seg_y_d[0] = next_y;
                            dir_cur_d  = dir_pend_q;
                            if (eat) begin
                                get_food_d = 1'b1;
                                if (eat_grow) begin
                                    length_d = length_q + 5'd1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    fsm_d = ST_DEAD;
                end
            endcase

            // Compare against the direction in effect after this cycle so that a
            // request arriving with a step cannot reverse into the neck.
            if ((game_state == GS_PLAY) && ((dir_req ^ dir_cur_d) != 2'b01)) begin
                dir_pend_d = dir_req;
            end
        end
    end

    // State registers with synchronous reset to the init configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x[i];
                seg_y_q[i] <= init_y[i];
            end
            length_q   <= INIT_LEN_V;
            dir_cur_q  <= DIR_RIGHT;
            dir_pend_q <= DIR_RIGHT;
            crash_q    <= 1'b0;
            get_food_q <= 1'b0;
            fsm_q      <= ST_INIT;
        end else begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_d[i];
                seg_y_q[i] <= seg_y_d[i];
            end
            length_q   <= length_d;
            dir_cur_q  <= dir_cur_d;
            dir_pend_q <= dir_pend_d;
            crash_q    <= crash_d;
            get_food_q <= get_food_d;
            fsm_q      <= fsm_d;
        end
    end

    assign head_x   = seg_x_q[0];
    assign head_y   = seg_y_q[0];
    assign length   = length_q;
    assign crash    = crash_q;
    assign get_food = get_food_q;

endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: directed checks of snake_body with the default size and a
// MAX_LEN=4 instance sharing the same stimulus.
module tb_snake_body;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] gs = 2'b00;
    logic       step = 1'b0;
    logic [1:0] dir = 2'b11;
    logic [4:0] fx = 5'd0, fy = 5'd0;
    logic [4:0] qx = 5'd0, qy = 5'd0;

    logic       gf, crash, qh;
    logic [4:0] hx, hy, len;
    logic       b_gf, b_crash, b_qh;
    logic [4:0] b_hx, b_hy, b_len;

    int cmp_cnt = 0;
    int err_cnt = 0;

    snake_body dut (
        .clk(clk), .rst(rst), .game_state(gs), .step(step), .dir_req(dir),
        .food_x(fx), .food_y(fy), .query_x(qx), .query_y(qy),
        .get_food(gf), .head_x(hx), .head_y(hy), .length(len),
        .crash(crash), .query_hit(qh)
    );

    snake_body #(.MAX_LEN(4), .INIT_LEN(3)) dut4 (
        .clk(clk), .rst(rst), .game_state(gs), .step(step), .dir_req(dir),
        .food_x(fx), .food_y(fy), .query_x(qx), .query_y(qy),
        .get_food(b_gf), .head_x(b_hx), .head_y(b_hy), .length(b_len),
        .crash(b_crash), .query_hit(b_qh)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
        $display("step: head=(%0d,%0d) len=%0d crash=%0d gf=%0d | max4 head=(%0d,%0d) len=%0d gf=%0d",
                 hx, hy, len, crash, gf, b_hx, b_hy, b_len, b_gf);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic probe(input logic [4:0] x, input logic [4:0] y);
        qx = x;
        qy = y;
        #1;
    endtask

    initial begin
        // Reset state
        rst = 1'b1; gs = 2'b00;
        tick();
        rst = 1'b0;
        chk("rst_hx", hx, 16);
        chk("rst_hy", hy, 12);
        chk("rst_len", len, 3);
        chk("rst_crash", crash, 0);
        chk("rst_gf", gf, 0);
        chk("rst_b_len", b_len, 3);

        // Start playing, three plain steps to the right
        gs = 2'b01; dir = 2'b11; fx = 5'd0; fy = 5'd0;
        tick();
        repeat (3) do_step();
        chk("run3_hx", hx, 19);
        chk("run3_hy", hy, 12);
        chk("run3_len", len, 3);
        chk("run3_gf", gf, 0);
        probe(5'd17, 5'd12); chk("run3_q_tail", qh, 1);
        probe(5'd16, 5'd12); chk("run3_q_vacated", qh, 0);

        // Eat at (20,12)
        fx = 5'd20; fy = 5'd12;
        do_step();
        chk("eat_gf", gf, 1);
        chk("eat_len", len, 4);
        chk("eat_hx", hx, 20);
        fx = 5'd0; fy = 5'd0;
        tick();
        chk("eat_gf_drop", gf, 0);
        probe(5'd17, 5'd12); chk("eat_q_tail", qh, 1);
        probe(5'd16, 5'd12); chk("eat_q_free", qh, 0);

        // Reverse request dropped, then turn up
        dir = 2'b10;
        tick();
        do_step();
        chk("rev_hx", hx, 21);
        chk("rev_hy", hy, 12);
        dir = 2'b00;
        tick();
        do_step();
        chk("up_hx", hx, 21);
        chk("up_hy", hy, 11);

        // Run into the right wall
        dir = 2'b11;
        tick();
        repeat (10) do_step();
        chk("edge_hx", hx, 31);
        chk("edge_crash", crash, 0);
        do_step();
        chk("wall_crash", crash, 1);
        chk("wall_hx", hx, 31);
        chk("wall_hy", hy, 11);
        chk("wall_len", len, 4);
        dir = 2'b01;
        tick();
        do_step();
        chk("dead_hy", hy, 11);
        chk("dead_crash", crash, 1);
        gs = 2'b00;
        tick();
        chk("idle_hx", hx, 16);
        chk("idle_hy", hy, 12);
        chk("idle_len", len, 3);
        chk("idle_crash", crash, 0);

        // Grow to 5, curl down/left/up into the body (food on the crash cell)
        dir = 2'b11; gs = 2'b01;
        tick();
        fx = 5'd17; fy = 5'd12;
        do_step();
        fx = 5'd18;
        do_step();
        chk("grow5_len", len, 5);
        fx = 5'd0; fy = 5'd0;
        dir = 2'b01; tick(); do_step();
        dir = 2'b10; tick(); do_step();
        chk("curl_hx", hx, 17);
        chk("curl_hy", hy, 13);
        fx = 5'd17; fy = 5'd12;
        dir = 2'b00; tick(); do_step();
        chk("self_crash", crash, 1);
        chk("self_gf", gf, 0);
        chk("self_len", len, 5);
        chk("self_hy", hy, 13);

        // Length 4: chasing the tail cell is legal
        gs = 2'b00; tick();
        gs = 2'b01; dir = 2'b11; tick();
        do_step();
        chk("tail4_len", len, 4);
        fx = 5'd0; fy = 5'd0;
        dir = 2'b01; tick(); do_step();
        dir = 2'b10; tick(); do_step();
        dir = 2'b00; tick(); do_step();
        chk("tail_crash", crash, 0);
        chk("tail_hx", hx, 16);
        chk("tail_hy", hy, 12);
        chk("tail_len", len, 4);

        // MAX_LEN=4 instance: saturation, pause, occupancy probes
        rst = 1'b1; gs = 2'b00;
        tick();
        rst = 1'b0;
        chk("b_rst_len", b_len, 3);
        chk("b_rst_hx", b_hx, 16);
        gs = 2'b01; dir = 2'b11;
        tick();
        fx = 5'd17; fy = 5'd12;
        do_step();
        chk("b_eat1_gf", b_gf, 1);
        chk("b_eat1_len", b_len, 4);
        fx = 5'd18;
        do_step();
        chk("b_eat2_gf", b_gf, 1);
        chk("b_eat2_len", b_len, 4);
        chk("b_eat2_hx", b_hx, 18);
        fx = 5'd0; fy = 5'd0;
        tick();
        chk("b_gf_drop", b_gf, 0);
        gs = 2'b10;
        repeat (2) do_step();
        chk("b_pause_hx", b_hx, 18);
        chk("b_pause_len", b_len, 4);
        chk("b_pause_crash", b_crash, 0);
        probe(5'd18, 5'd12); chk("b_q_head", b_qh, 1);
        probe(5'd15, 5'd12); chk("b_q_tail", b_qh, 1);
        probe(5'd14, 5'd12); chk("b_q_past_tail", b_qh, 0);
        probe(5'd5, 5'd5);   chk("b_q_free", b_qh, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
